// File: rtl/dcm_posctrl.sv
// dcm_posctrl: multi-channel closed-loop DC motor position controller.
// Each channel has its own register file, duty ramp, direction-reversal guard,
// stall timer and status block. All channels share one PWM counter and one
// ramp prescaler. They sit behind a simple synchronous register bus.

module dcm_posctrl_ch #(
  parameter int POS_W   = 24,
  parameter int PWM_W   = 8,
  parameter int STALL_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PWM_W-1:0] cnt,
  input  logic             ramp_tick,
  input  logic             we,
  input  logic [2:0]       field,
  input  logic [POS_W-1:0] wdata,
  input  logic             pulse_in,
  input  logic             fault_in,
  input  logic             otw_in,
  output logic [POS_W-1:0] rd_data,
  output logic             left,
  output logic             right,
  output logic             irq_req
);

  logic [2:0]         ctrl;       // {irq_en, brake, enable}
  logic [POS_W-1:0]   target;
  logic [POS_W-1:0]   position;
  logic [PWM_W-1:0]   max_duty;
  logic [PWM_W-1:0]   ramp_step;
  logic [3:0]         status;     // {at_target, stall, fault, otw}
  logic [PWM_W-1:0]   duty;
  logic               drive_left; // 0 = right, 1 = left; sticky between moves
  logic [STALL_W-1:0] stall_timer;
  logic               delta_zero_q;
  logic [2:0]         pulse_sync; // [1:0] synchroniser, [2] edge history
  logic [1:0]         fault_sync;
  logic [1:0]         otw_sync;

  logic [POS_W-1:0] delta;
  logic             delta_zero, want_left, want_right, reversing;
  logic             fault_now, otw_now, blocked, pulse;
  logic             stall_hit, at_hit, brake_on, pwm_on;
  logic [PWM_W-1:0] goal, duty_step;
  logic [3:0]       status_set, status_clr;

  assign delta      = target - position;
  assign delta_zero = (delta == '0);
  assign want_left  = delta[POS_W-1];
  assign want_right = !delta[POS_W-1] && !delta_zero;
  // Wanted direction disagrees with the bridge polarity: coast down first.
  assign reversing  = (want_left || want_right) && (want_left != drive_left);

  assign fault_now  = fault_sync[1];
  assign otw_now    = otw_sync[1];
  assign pulse      = pulse_sync[1] && !pulse_sync[2];
  // The raw synced inputs are included so duty drops on the same edge the bit sets.
  assign blocked    = (|status[2:0]) || fault_now || otw_now;
  assign goal       = (ctrl[0] && !blocked && !delta_zero && !reversing) ? max_duty : '0;

  assign stall_hit  = (duty != '0) && (&stall_timer);
  assign at_hit     = ctrl[0] && delta_zero && !delta_zero_q;
  assign brake_on   = ctrl[1] && (duty == '0) &&
                      !(status[0] || status[1] || fault_now || otw_now);
  assign pwm_on     = (cnt < duty);

  assign status_set = {at_hit, stall_hit, fault_now, otw_now};
  assign status_clr = (we && field == 3'd5) ? wdata[3:0] : 4'b0;
  assign irq_req    = ctrl[2] && (|status);

  // One ramp step toward goal, landing exactly on goal when within reach.
  always_comb begin
    duty_step = duty;
    if (duty < goal)
      duty_step = ((goal - duty) <= ramp_step) ? goal : duty + ramp_step;
    else if (duty > goal)
      duty_step = ((duty - goal) <= ramp_step) ? goal : duty - ramp_step;
  end

  // Register read mux; unused fields read as zero.
  always_comb begin
    rd_data = '0;
    case (field)
      3'd0:    rd_data = POS_W'(ctrl);
      3'd1:    rd_data = target;
      3'd2:    rd_data = position;
      3'd3:    rd_data = POS_W'(max_duty);
      3'd4:    rd_data = POS_W'(ramp_step);
      3'd5:    rd_data = POS_W'(status);
      default: rd_data = '0;
    endcase
  end

  // Two-flop synchronisers plus one history flop for pulse edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_sync <= '0;
      fault_sync <= '0;
      otw_sync   <= '0;
    end else begin
      pulse_sync <= {pulse_sync[1:0], pulse_in};
      fault_sync <= {fault_sync[0], fault_in};
      otw_sync   <= {otw_sync[0], otw_in};
    end
  end

  // Software registers, position tracking, duty ramp, stall timer and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl         <= '0;
      target       <= '0;
      position     <= '0;
      max_duty     <= '0;
      ramp_step    <= '0;
      status       <= '0;
      duty         <= '0;
      drive_left   <= 1'b0;
      stall_timer  <= '0;
      delta_zero_q <= 1'b0;
    end else begin
      if (we && field == 3'd0) ctrl      <= wdata[2:0];
      if (we && field == 3'd1) target    <= wdata;
      if (we && field == 3'd3) max_duty  <= wdata[PWM_W-1:0];
      if (we && field == 3'd4) ramp_step <= wdata[PWM_W-1:0];

      // A preset write beats a coincident pulse; coasting pulses still count.
      if (we && field == 3'd2)
        position <= wdata;
      else if (pulse)
        position <= drive_left ? position - POS_W'(1) : position + POS_W'(1);

      // Clear wins this cycle; a persisting cause re-sets the bit next cycle.
      status <= (status | status_set) & ~status_clr;

      if (blocked)
        duty <= '0;
      else if (ramp_step == '0)
        duty <= goal;
      else if (ramp_tick)
        duty <= duty_step;

      // Bridge polarity may only flip with the output fully off.
      if ((duty == '0) && (want_left || want_right))
        drive_left <= want_left;

      if ((duty == '0) || pulse)
        stall_timer <= '0;
      else
        stall_timer <= stall_timer + STALL_W'(1);

      delta_zero_q <= delta_zero;
    end
  end

  // Registered H-bridge outputs; brake shorts both low-side legs high.
  always_ff @(posedge clk) begin
    if (reset) begin
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      left  <= brake_on || (drive_left && pwm_on);
      right <= brake_on || (!drive_left && pwm_on);
    end
  end

endmodule

module dcm_posctrl #(
  parameter int N_CHANNELS = 6,
  parameter int POS_W      = 24,
  parameter int PWM_W      = 8,
  parameter int STALL_W    = 20,
  parameter int RAMP_DIV_W = 8,
  parameter int ADDR_W     = $clog2(N_CHANNELS) + 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_we,
  input  logic                  reg_re,
  input  logic [ADDR_W-1:0]     reg_addr,
  input  logic [POS_W-1:0]      reg_wdata,
  output logic [POS_W-1:0]      reg_rdata,
  output logic                  reg_rvalid,
  input  logic [N_CHANNELS-1:0] motor_pulse,
  input  logic [N_CHANNELS-1:0] motor_fault,
  input  logic [N_CHANNELS-1:0] motor_otw,
  output logic [N_CHANNELS-1:0] motor_left,
  output logic [N_CHANNELS-1:0] motor_right,
  output logic                  irq
);

  logic [PWM_W-1:0]                 pwm_cnt;
  logic [RAMP_DIV_W-1:0]            ramp_cnt;
  logic                             ramp_tick;
  logic [ADDR_W-1:0]                chan;
  logic [N_CHANNELS-1:0][POS_W-1:0] ch_rd;
  logic [N_CHANNELS-1:0]            ch_irq;
  logic [N_CHANNELS-1:0]            ch_we;
  logic [POS_W-1:0]                 rd_sel;

  assign ramp_tick = &ramp_cnt;
  // Upper address bits select the channel; out-of-range channels match nothing.
  assign chan      = reg_addr >> 3;

  // Shared free-running PWM counter and ramp prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + PWM_W'(1);
      ramp_cnt <= ramp_cnt + RAMP_DIV_W'(1);
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    assign ch_we[i] = reg_we && (chan == ADDR_W'(i));

    dcm_posctrl_ch #(
      .POS_W   (POS_W),
      .PWM_W   (PWM_W),
      .STALL_W (STALL_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cnt       (pwm_cnt),
      .ramp_tick (ramp_tick),
      .we        (ch_we[i]),
      .field     (reg_addr[2:0]),
      .wdata     (reg_wdata),
      .pulse_in  (motor_pulse[i]),
      .fault_in  (motor_fault[i]),
      .otw_in    (motor_otw[i]),
      .rd_data   (ch_rd[i]),
      .left      (motor_left[i]),
      .right     (motor_right[i]),
      .irq_req   (ch_irq[i])
    );
  end

  // Channel select for reads; unmatched channel index reads zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_CHANNELS; i++)
      if (chan == ADDR_W'(i)) rd_sel = ch_rd[i];
  end

  // Registered read port and interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
      irq        <= 1'b0;
    end else begin
      reg_rdata  <= reg_re ? rd_sel : '0;
      reg_rvalid <= reg_re;
      irq        <= |ch_irq;
    end
  end

endmodule

// File: tb/tb_dcm_posctrl.sv
// Directed bench for dcm_posctrl: reset, forward move, reversal, wrap/preset,
// stall, fault/brake, otw and register-bus corner cases.

module tb_dcm_posctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_we, reg_re;
  logic [5:0]  reg_addr;
  logic [23:0] reg_wdata, reg_rdata;
  logic        reg_rvalid;
  logic [5:0]  motor_pulse, motor_fault, motor_otw;
  logic [5:0]  motor_left, motor_right;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  dcm_posctrl #(
    .N_CHANNELS (6),
    .POS_W      (24),
    .PWM_W      (8),
    .STALL_W    (10),
    .RAMP_DIV_W (2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .reg_rvalid  (reg_rvalid),
    .motor_pulse (motor_pulse),
    .motor_fault (motor_fault),
    .motor_otw   (motor_otw),
    .motor_left  (motor_left),
    .motor_right (motor_right),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input int f, input logic [23:0] d);
    @(negedge clk);
    reg_we    = 1'b1;
    reg_addr  = {3'(ch), 3'(f)};
    reg_wdata = d;
    @(negedge clk);
    reg_we    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int ch, input int f, input logic [23:0] exp);
    @(negedge clk);
    reg_re   = 1'b1;
    reg_addr = {3'(ch), 3'(f)};
    @(negedge clk);
    reg_re   = 1'b0;
    chk(tag, reg_rdata, exp);
  endtask

  // High-time of both bridge legs over one full PWM period (256 clk).
  task automatic pwm_meas(input int ch, output int l, output int r, output int both);
    l = 0; r = 0; both = 0;
    repeat (256) begin
      @(negedge clk);
      l += int'(motor_left[ch]);
      r += int'(motor_right[ch]);
      if (motor_left[ch] && motor_right[ch]) both++;
    end
  endtask

  task automatic pulse(input int ch);
    motor_pulse[ch] = 1'b1;
    repeat (3) @(negedge clk);
    motor_pulse[ch] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int l, r, b, early_l, overlap;
    reset = 1'b1; reg_we = 0; reg_re = 0; reg_addr = '0; reg_wdata = '0;
    motor_pulse = '0; motor_fault = '0; motor_otw = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_left", motor_left, 0);
    chk("rst_right", motor_right, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rvalid", reg_rvalid, 0);

    // reset mid-move on channel 1 at duty 200
    wr(1, 3, 200); wr(1, 4, 0); wr(1, 1, 50); wr(1, 0, 1);
    repeat (4) @(negedge clk);
    pwm_meas(1, l, r, b);
    chk("mm_right_duty", r, 200);
    chk("mm_left_duty", l, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mm_rst_left", motor_left, 0);
    chk("mm_rst_right", motor_right, 0);
    chk("mm_rst_irq", irq, 0);
    rd_chk("mm_pos", 1, 2, 0);
    rd_chk("mm_ctrl", 1, 0, 0);
    rd_chk("mm_maxduty", 1, 3, 0);
    pwm_meas(1, l, r, b);
    chk("mm_duty0", r + l, 0);

    // forward move on channel 0
    wr(0, 3, 128); wr(0, 4, 0); wr(0, 1, 5); wr(0, 0, 5);
    repeat (4) @(negedge clk);
    pwm_meas(0, l, r, b);
    chk("fwd_right_duty", r, 128);
    chk("fwd_left_duty", l, 0);
    chk("fwd_irq_idle", irq, 0);
    repeat (5) pulse(0);
    rd_chk("fwd_pos", 0, 2, 5);
    rd_chk("fwd_status", 0, 5, 24'h8);
    repeat (4) @(negedge clk);
    pwm_meas(0, l, r, b);
    chk("fwd_off", r + l, 0);
    chk("fwd_irq", irq, 1);
    wr(0, 5, 24'hF);
    repeat (2) @(negedge clk);
    chk("fwd_irq_clr", irq, 0);
    rd_chk("fwd_status_clr", 0, 5, 0);

    // reversal on channel 2
    wr(2, 3, 64); wr(2, 4, 16); wr(2, 1, 100); wr(2, 0, 1);
    repeat (40) @(negedge clk);
    pwm_meas(2, l, r, b);
    chk("rev_right_duty", r, 64);
    wr(2, 1, 24'hFFFFF6);
    early_l = 0; overlap = 0;
    repeat (12) begin
      @(negedge clk);
      early_l += int'(motor_left[2]);
      if (motor_left[2] && motor_right[2]) overlap++;
    end
    chk("rev_early_left", early_l, 0);
    repeat (60) begin
      @(negedge clk);
      if (motor_left[2] && motor_right[2]) overlap++;
    end
    pwm_meas(2, l, r, b);
    chk("rev_left_duty", l, 64);
    chk("rev_right_off", r, 0);
    chk("rev_overlap", overlap + b, 0);

    // wrap and preset on channel 2 (driving left)
    rd_chk("wrap_pos0", 2, 2, 0);
    pulse(2);
    rd_chk("wrap_pos", 2, 2, 24'hFFFFFF);
    motor_pulse[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reg_we = 1'b1; reg_addr = {3'd2, 3'd2}; reg_wdata = 24'h123456;
    @(negedge clk);
    reg_we = 1'b0;
    motor_pulse[2] = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("preset_pos", 2, 2, 24'h123456);
    wr(2, 0, 0);

    // stall on channel 3 (timeout 1024 clk)
    wr(3, 3, 100); wr(3, 4, 0); wr(3, 1, 1000); wr(3, 0, 1);
    repeat (1000) @(negedge clk);
    rd_chk("stall_early", 3, 5, 0);
    repeat (40) @(negedge clk);
    rd_chk("stall_set", 3, 5, 24'h4);
    chk("stall_irq_masked", irq, 0);
    pwm_meas(3, l, r, b);
    chk("stall_duty0", r + l, 0);
    wr(3, 5, 24'h4);
    repeat (4) @(negedge clk);
    pwm_meas(3, l, r, b);
    chk("stall_resume", r, 100);
    wr(3, 0, 0);

    // fault and brake on channel 4
    wr(4, 0, 6);
    repeat (3) @(negedge clk);
    chk("brake_left", motor_left[4], 1);
    chk("brake_right", motor_right[4], 1);
    motor_fault[4] = 1'b1;
    repeat (3) @(negedge clk);
    chk("fault_left", motor_left[4], 0);
    chk("fault_right", motor_right[4], 0);
    rd_chk("fault_status", 4, 5, 24'h2);
    chk("fault_irq", irq, 1);
    wr(4, 5, 24'h2);
    rd_chk("fault_reset", 4, 5, 24'h2);
    motor_fault[4] = 1'b0;
    repeat (5) @(negedge clk);
    rd_chk("fault_sticky", 4, 5, 24'h2);
    chk("fault_brake_off", motor_left[4], 0);
    wr(4, 5, 24'h2);
    repeat (3) @(negedge clk);
    chk("brake_back_left", motor_left[4], 1);
    chk("brake_back_right", motor_right[4], 1);
    chk("brake_irq_clr", irq, 0);

    // over-temperature on channel 5
    motor_otw[5] = 1'b1;
    repeat (4) @(negedge clk);
    motor_otw[5] = 1'b0;
    rd_chk("otw_status", 5, 5, 24'h1);

    // register bus corners
    rd_chk("field6_zero", 5, 6, 0);
    wr(7, 1, 24'h55);
    rd_chk("bad_chan", 7, 1, 0);
    @(negedge clk);
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = {3'd5, 3'd1}; reg_wdata = 24'h777;
    @(negedge clk);
    reg_we = 1'b0; reg_re = 1'b0;
    chk("rw_same_old", reg_rdata, 0);
    chk("rw_rvalid", reg_rvalid, 1);
    @(negedge clk);
    chk("rvalid_drop", reg_rvalid, 0);
    rd_chk("rw_same_new", 5, 1, 24'h777);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
